miner_core_sequencer: RTL and testbench
=======================================

Name: miner_core_sequencer

Overview:
Round sequencer for one miner core. It drives the enable/rollover side of the core timer and consumes that timer's count and rollover flag. It walks a nonce range: per nonce it loads the message, runs ROUNDS compression rounds, then samples the datapath hit flag. It sits between the job dispatcher (start/done) and the hash datapath plus core timer.

Parameters:
ROUNDS, 64, compression rounds per nonce; driven onto rollover_val; legal range 2..2^CNT_W-1
CNT_W, 7, width of timer count/rollover_val
NONCE_W, 32, nonce width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  job request; honoured only in IDLE
nonce_first  in  NONCE_W  first nonce of range; latched on accepted start
nonce_last  in  NONCE_W  last nonce of range, inclusive; latched on accepted start
hash_hit  in  1  datapath result for current nonce; valid in CHECK only
count  in  CNT_W  timer count; round index for datapath
rollover_flag  in  1  timer rollover flag
enable_timer  out  1  timer count enable
rollover_val  out  CNT_W  constant ROUNDS
load_msg  out  1  one-cycle pulse; datapath loads message with current nonce
round_idx  out  CNT_W  count passed through combinationally
nonce  out  NONCE_W  current nonce
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at job end
found  out  1  high with done when a hit ended the job; held until next accepted start
found_nonce  out  NONCE_W  nonce that hit; held until next accepted start

Behaviour:
- Reset (async, rst=1): state IDLE; enable_timer, load_msg, done, found, busy = 0; nonce, found_nonce = 0; roll_q = 0. The timer resets to count 0 with flag 0 on the same reset net.
- rollover_val = ROUNDS at all times, including during reset.
- roll_q is a registered copy of rollover_flag. A round-set completes only on the rising edge: rollover_flag=1 and roll_q=0. This rejects the stale flag that stays high while the timer holds at ROUNDS.
- IDLE: if start=1, latch nonce_first into nonce and nonce_last into an internal register, clear found and found_nonce, go to LOAD. A start outside IDLE is ignored.
- LOAD, 1 cycle: load_msg=1, enable_timer=0; next state ROUND.
- ROUND: enable_timer=1. On a rollover rising edge go to CHECK; enable_timer is 0 from that next cycle. Timer latency is ROUNDS cycles from the first ROUND cycle.
- CHECK, 1 cycle: enable_timer=0.
  - hash_hit=1: found_nonce<=nonce, found<=1, go to DONE.
  - Otherwise, if nonce==nonce_last: go to DONE with found=0.
  - Otherwise: nonce<=nonce+1 (mod 2^NONCE_W), go to LOAD.
- DONE, 1 cycle: done=1; next state IDLE; busy drops with IDLE.
- Per-nonce cost: ROUNDS+2 cycles (LOAD + ROUNDS + CHECK), plus 1 DONE cycle per job.
- Boundaries:
  - nonce_first==nonce_last: exactly one nonce is processed.
  - nonce_last<nonce_first: the range wraps through 2^NONCE_W-1 to 0.
  - A hit on the last nonce reports found=1.
  - hash_hit outside CHECK is ignored.
  - start asserted in the DONE cycle is ignored; start in the following IDLE cycle is accepted.
  - rst mid-job aborts immediately to reset values; no done pulse.

Optional Feature:
MINER_ABORT_EN
- Defined: adds input abort (1 bit). abort=1 in LOAD, ROUND or CHECK moves to DONE next cycle with found=0 and enable_timer=0. Abort has priority over a hit in the same CHECK cycle. The timer is left holding its count; the next job's rising-edge rule still holds, because the count restarts from the held value. For this reason, with the macro defined, ROUND also waits for count==ROUNDS on the rising edge.
- Undefined: no abort port; jobs run to hit or range end.

Test Plan:
- ROUNDS=4, nonce range 5..7, hash_hit never set -> three load_msg pulses with nonce=5,6,7; done at cycle 1+3*6+1 after start; found=0.
- Range 10..20, hash_hit=1 in the CHECK for nonce 12 -> done with found=1, found_nonce=12; nonce 13 is never loaded.
- nonce_first=32'hFFFF_FFFE, nonce_last=1 -> nonces FFFFFFFE, FFFFFFFF, 0, 1 are processed, then done.
- Stale flag: a second nonce starts while rollover_flag is still high from the previous rollover -> ROUND lasts exactly ROUNDS cycles, not 1.
- rst pulsed during ROUND of a 3-nonce job -> all outputs reset within the reset cycle, no done; a new start runs a full job correctly.
- With MINER_ABORT_EN: abort during ROUND of nonce 7 -> done next cycle, found=0; abort together with hash_hit in CHECK -> found=0.

Source files
------------

// File: rtl/miner_core_sequencer.sv
// Round sequencer for one miner core: walks a nonce range, runs ROUNDS timer-paced rounds per nonce.
// Optional feature macro: MINER_ABORT_EN adds an abort input that ends a job early with found=0.
module miner_core_sequencer #(
  parameter int ROUNDS  = 64,
  parameter int CNT_W   = 7,
  parameter int NONCE_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [NONCE_W-1:0] nonce_first,
  input  logic [NONCE_W-1:0] nonce_last,
  input  logic               hash_hit,
  input  logic [CNT_W-1:0]   count,
  input  logic               rollover_flag,
`ifdef MINER_ABORT_EN
  input  logic               abort,
`endif
  output logic               enable_timer,
  output logic [CNT_W-1:0]   rollover_val,
  output logic               load_msg,
  output logic [CNT_W-1:0]   round_idx,
  output logic [NONCE_W-1:0] nonce,
  output logic               busy,
  output logic               done,
  output logic               found,
  output logic [NONCE_W-1:0] found_nonce,
  output logic [2:0]         state_dbg
);

  // Handshake: start is a request sampled only while busy=0 (IDLE); the job ends with a
  // one-cycle done pulse and busy falls in the following cycle, when a new start is taken.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ROUND = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t             state;
  logic [NONCE_W-1:0] nonce_last_q;
  logic               roll_q;
  logic               roll_rise;
  logic               round_end;

  assign rollover_val = CNT_W'(ROUNDS);
  assign round_idx    = count;
  assign state_dbg    = state;

  // The timer parks with its flag high; only a fresh rising edge ends a round set.
  assign roll_rise = rollover_flag && !roll_q;
`ifdef MINER_ABORT_EN
  assign round_end = roll_rise && (count == CNT_W'(ROUNDS));
`else
  assign round_end = roll_rise;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      enable_timer <= 1'b0;
      load_msg     <= 1'b0;
      done         <= 1'b0;
      found        <= 1'b0;
      busy         <= 1'b0;
      nonce        <= '0;
      found_nonce  <= '0;
      nonce_last_q <= '0;
      roll_q       <= 1'b0;
    end else begin
      roll_q   <= rollover_flag;
      load_msg <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            nonce        <= nonce_first;
            nonce_last_q <= nonce_last;
            found        <= 1'b0;
            found_nonce  <= '0;
            load_msg     <= 1'b1;
            busy         <= 1'b1;
            state        <= LOAD;
          end
        end
        LOAD: begin
          enable_timer <= 1'b1;
          state        <= ROUND;
        end
        ROUND: begin
          if (round_end) begin
            enable_timer <= 1'b0;
            state        <= CHECK;
          end
        end
        CHECK: begin
          if (hash_hit) begin
            found_nonce <= nonce;
            found       <= 1'b1;
            done        <= 1'b1;
            state       <= DONE;
          end else if (nonce == nonce_last_q) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            nonce    <= nonce + NONCE_W'(1);
            load_msg <= 1'b1;
            state    <= LOAD;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          enable_timer <= 1'b0;
          busy         <= 1'b0;
          state        <= IDLE;
        end
      endcase
`ifdef MINER_ABORT_EN
      // Abort wins over everything in flight, including a hit in CHECK.
      if (abort && (state == LOAD || state == ROUND || state == CHECK)) begin
        enable_timer <= 1'b0;
        load_msg     <= 1'b0;
        found        <= 1'b0;
        found_nonce  <= found_nonce;
        nonce        <= nonce;
        done         <= 1'b1;
        state        <= DONE;
      end
`endif
    end
  end

endmodule

// File: tb/tb_miner_core_sequencer.sv
// Bench for miner_core_sequencer: timer and datapath models, table-driven jobs, scoreboard of loaded nonces.
module tb_miner_core_sequencer;

  localparam int ROUNDS  = 4;
  localparam int CNT_W   = 7;
  localparam int NONCE_W = 32;
  localparam int BUDGET  = 400;

  logic               clk;
  logic               rst;
  logic               start;
  logic [NONCE_W-1:0] nonce_first;
  logic [NONCE_W-1:0] nonce_last;
  logic               hash_hit;
  logic [CNT_W-1:0]   count;
  logic               rollover_flag;
  logic               enable_timer;
  logic [CNT_W-1:0]   rollover_val;
  logic               load_msg;
  logic [CNT_W-1:0]   round_idx;
  logic [NONCE_W-1:0] nonce;
  logic               busy;
  logic               done;
  logic               found;
  logic [NONCE_W-1:0] found_nonce;
  logic [2:0]         state_dbg;

  miner_core_sequencer #(.ROUNDS(ROUNDS), .CNT_W(CNT_W), .NONCE_W(NONCE_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .nonce_first(nonce_first), .nonce_last(nonce_last),
    .hash_hit(hash_hit), .count(count), .rollover_flag(rollover_flag),
    .enable_timer(enable_timer), .rollover_val(rollover_val),
    .load_msg(load_msg), .round_idx(round_idx), .nonce(nonce),
    .busy(busy), .done(done), .found(found), .found_nonce(found_nonce),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Core timer model: counts while enabled, flags on its last round, then parks at ROUNDS
  // with the flag still high until the next enabled period restarts it at 1.
  logic [CNT_W-1:0] tcount;
  always @(posedge clk or posedge rst) begin
    if (rst) tcount <= '0;
    else if (enable_timer) tcount <= (tcount == CNT_W'(ROUNDS)) ? CNT_W'(1) : tcount + CNT_W'(1);
  end
  always @(*) begin
    count         = tcount;
    rollover_flag = (tcount >= CNT_W'(ROUNDS - 1));
  end

  // Datapath model: hits whenever the current nonce matches; the DUT must only listen in CHECK.
  logic               hit_en;
  logic [NONCE_W-1:0] hit_nonce;
  always @(*) hash_hit = hit_en && (nonce == hit_nonce);

  // scoreboard
  logic [NONCE_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int last_load;
  bit spacing_valid = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (!rst && load_msg) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL load_extra: nonce %0h loaded, expected no load (cycle %0d)", nonce, cyc);
      end else begin
        logic [NONCE_W-1:0] e;
        e = exp_q.pop_front();
        check("load_nonce", 64'(nonce), 64'(e));
        if (spacing_valid) check("load_spacing", 64'(cyc - last_load), 64'(ROUNDS + 2));
        last_load     = cyc;
        spacing_valid = 1;
      end
    end
  end

  // Reference walk over a range: pushes each nonce that should be loaded.
  task automatic model_job(input logic [NONCE_W-1:0] f, input logic [NONCE_W-1:0] l,
                           input logic he, input logic [NONCE_W-1:0] h,
                           output int loads, output logic fo, output logic [NONCE_W-1:0] fno);
    logic [NONCE_W-1:0] n;
    n = f; loads = 0; fo = 1'b0; fno = '0;
    for (int k = 0; k < 64; k++) begin
      exp_q.push_back(n);
      loads++;
      if (he && n == h) begin fo = 1'b1; fno = n; break; end
      if (n == l) break;
      n = n + 1;
    end
  endtask

  task automatic wait_done(output int waits);
    waits = 0;
    while (!done && waits < BUDGET) begin
      @(negedge clk);
      waits++;
    end
  endtask

  // driver: called at a negedge with the DUT idle
  task automatic run_job(input logic [NONCE_W-1:0] f, input logic [NONCE_W-1:0] l,
                         input logic he, input logic [NONCE_W-1:0] h,
                         input int exp_loads, input logic ef, input logic [NONCE_W-1:0] efn);
    int waits;
    hit_en = he; hit_nonce = h; spacing_valid = 0;
    nonce_first = f; nonce_last = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", 64'(busy), 64'd1);
    check("start_found_clr", 64'(found), 64'd0);
    check("start_found_nonce_clr", 64'(found_nonce), 64'd0);
    check("round_idx_pass", 64'(round_idx), 64'(tcount));
    wait_done(waits);
    check("done_latency", 64'(waits), 64'(exp_loads * (ROUNDS + 2)));
    check("done_found", 64'(found), 64'(ef));
    check("done_found_nonce", 64'(found_nonce), 64'(efn));
    check("done_queue_empty", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_done_pulse", 64'(done), 64'd0);
    check("idle_found_held", 64'(found), 64'(ef));
  endtask

  typedef struct {
    logic [NONCE_W-1:0] first;
    logic [NONCE_W-1:0] last;
    logic               hit_en;
    logic [NONCE_W-1:0] hit;
    int                 exp_loads;
    logic               exp_found;
    logic [NONCE_W-1:0] exp_fn;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int                 ml, waits;
    logic               mf;
    logic [NONCE_W-1:0] mfn, rf, rl, rh;
    logic               rhe;

    vecs[0] = '{32'd5,          32'd7,  1'b0, 32'd0,  3, 1'b0, 32'd0};
    vecs[1] = '{32'd10,         32'd20, 1'b1, 32'd12, 3, 1'b1, 32'd12};
    vecs[2] = '{32'hFFFF_FFFE,  32'd1,  1'b0, 32'd0,  4, 1'b0, 32'd0};
    vecs[3] = '{32'd9,          32'd9,  1'b0, 32'd0,  1, 1'b0, 32'd0};
    vecs[4] = '{32'd9,          32'd9,  1'b1, 32'd9,  1, 1'b1, 32'd9};
    vecs[5] = '{32'd30,         32'd33, 1'b1, 32'd33, 4, 1'b1, 32'd33};

    rst = 1'b1; start = 1'b0; nonce_first = '0; nonce_last = '0;
    hit_en = 1'b0; hit_nonce = '0;
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_load_msg", 64'(load_msg), 64'd0);
    check("rst_enable_timer", 64'(enable_timer), 64'd0);
    check("rst_found", 64'(found), 64'd0);
    check("rst_nonce", 64'(nonce), 64'd0);
    check("rst_found_nonce", 64'(found_nonce), 64'd0);
    check("rst_state", 64'(state_dbg), 64'd0);
    check("rst_rollover_val", 64'(rollover_val), 64'(ROUNDS));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      model_job(vecs[i].first, vecs[i].last, vecs[i].hit_en, vecs[i].hit, ml, mf, mfn);
      run_job(vecs[i].first, vecs[i].last, vecs[i].hit_en, vecs[i].hit,
              vecs[i].exp_loads, vecs[i].exp_found, vecs[i].exp_fn);
    end

    for (int i = 0; i < 3; i++) begin
      rf  = $urandom;
      rl  = rf + NONCE_W'($urandom_range(0, 3));
      rhe = 1'($urandom_range(0, 1));
      rh  = rf + NONCE_W'($urandom_range(0, 4));
      model_job(rf, rl, rhe, rh, ml, mf, mfn);
      run_job(rf, rl, rhe, rh, ml, mf, mfn);
    end

    // start held in the DONE cycle is ignored, then taken in the next IDLE cycle
    model_job(32'd5, 32'd5, 1'b0, 32'd0, ml, mf, mfn);
    hit_en = 1'b0; spacing_valid = 0;
    nonce_first = 32'd5; nonce_last = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(waits);
    check("dc_first_latency", 64'(waits), 64'(ROUNDS + 2));
    model_job(32'd100, 32'd100, 1'b0, 32'd0, ml, mf, mfn);
    spacing_valid = 0;
    nonce_first = 32'd100; nonce_last = 32'd100; start = 1'b1;
    @(negedge clk);
    check("dc_start_ignored_busy", 64'(busy), 64'd0);
    check("dc_start_ignored_load", 64'(load_msg), 64'd0);
    @(negedge clk);
    start = 1'b0;
    check("dc_start_accepted", 64'(busy), 64'd1);
    wait_done(waits);
    check("dc_second_latency", 64'(waits), 64'(ROUNDS + 2));
    check("dc_queue_empty", 64'(exp_q.size()), 64'd0);
    @(negedge clk);

    // reset in the middle of ROUND aborts with no done pulse
    model_job(32'd20, 32'd22, 1'b0, 32'd0, ml, mf, mfn);
    spacing_valid = 0;
    nonce_first = 32'd20; nonce_last = 32'd22; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_timer_on", 64'(enable_timer), 64'd1);
    rst = 1'b1;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_enable_timer", 64'(enable_timer), 64'd0);
    check("midrst_nonce", 64'(nonce), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_state", 64'(state_dbg), 64'd0);
    check("midrst_rollover_val", 64'(rollover_val), 64'(ROUNDS));
    exp_q.delete();
    @(negedge clk);
    check("midrst_no_done", 64'(done), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    model_job(32'd40, 32'd42, 1'b1, 32'd41, ml, mf, mfn);
    run_job(32'd40, 32'd42, 1'b1, 32'd41, 2, 1'b1, 32'd41);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

endmodule
